arp_req_arbiter: RTL and testbench

//  Shares the single ARP-lookup request/response channel of the arp block among N_PORTS requesters
//  (e.g. the IP TX path, UDP and a management port). Round-robin arbitration; one lookup in flight.

---
 rtl/arp_req_arbiter.sv | 146 ++++++++++++++
 tb/tb_arp_req_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_req_arbiter.sv
// arp_req_arbiter
//   Shares one ARP lookup request/response channel among N_PORTS requesters.
//   Arbitration is round-robin, and only one lookup is in flight at a time.
//   The response is returned to the port that issued the request.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   s_arp_request_*        per-port request side (valid/ready/ip, ip packed 32b per port)
//   s_arp_response_*       per-port response valid/ready, shared error/mac
//   m_arp_request_*        toward the arp block request channel
//   m_arp_response_*       from the arp block response channel
//   busy                   high whenever a lookup is owned by some port
//   grant_id               port owning the current (or last) lookup
module arp_req_arbiter #(
    parameter int N_PORTS = 4,
    parameter int PTR_W   = $clog2(N_PORTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_PORTS-1:0]     s_arp_request_valid,
    output logic [N_PORTS-1:0]     s_arp_request_ready,
    input  logic [32*N_PORTS-1:0]  s_arp_request_ip,
    output logic [N_PORTS-1:0]     s_arp_response_valid,
    input  logic [N_PORTS-1:0]     s_arp_response_ready,
    output logic                   s_arp_response_error,
    output logic [47:0]            s_arp_response_mac,
    output logic                   m_arp_request_valid,
    input  logic                   m_arp_request_ready,
    output logic [31:0]            m_arp_request_ip,
    input  logic                   m_arp_response_valid,
    output logic                   m_arp_response_ready,
    input  logic                   m_arp_response_error,
    input  logic [47:0]            m_arp_response_mac,
    output logic                   busy,
    output logic [PTR_W-1:0]       grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                     state;
    logic [PTR_W-1:0]           rr_ptr;
    logic [PTR_W-1:0]           grant_q;
    logic [PTR_W-1:0]           sel;
    logic                       sel_found;
    logic [PTR_W:0]             cand;
    logic [N_PORTS-1:0][31:0]   req_ip_a;
    logic [31:0]                ip_q;
    logic [47:0]                mac_q;
    logic                       err_q;
    logic                       m_req_vld_q;
    logic                       m_rsp_rdy_q;
    logic [N_PORTS-1:0]         s_rsp_vld_q;

    assign req_ip_a = s_arp_request_ip;

    function automatic logic [N_PORTS-1:0] onehot(input logic [PTR_W-1:0] p);
        logic [N_PORTS-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: scan rr_ptr, rr_ptr+1, ... and wrap explicitly at
    // N_PORTS. The wrap is written out instead of relying on PTR_W overflow,
    // so non-power-of-2 port counts never form an out-of-range index.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(N_PORTS))
                cand = cand - (PTR_W+1)'(N_PORTS);
            if (!sel_found && s_arp_request_valid[cand[PTR_W-1:0]]) begin
                sel       = cand[PTR_W-1:0];
                sel_found = 1'b1;
            end
        end
    end

    // The accept path is combinational so that a port is granted on the
    // same edge it is selected. That edge is also the transfer edge.
    assign s_arp_request_ready  = (state == IDLE && sel_found) ? onehot(sel) : '0;

    assign m_arp_request_valid  = m_req_vld_q;
    assign m_arp_request_ip     = ip_q;
    assign m_arp_response_ready = m_rsp_rdy_q;
    assign s_arp_response_valid = s_rsp_vld_q;
    assign s_arp_response_error = err_q;
    assign s_arp_response_mac   = mac_q;
    assign busy                 = (state != IDLE);
    assign grant_id             = grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_q     <= '0;
            ip_q        <= '0;
            mac_q       <= '0;
            err_q       <= 1'b0;
            m_req_vld_q <= 1'b0;
            m_rsp_rdy_q <= 1'b0;
            s_rsp_vld_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_q     <= sel;
                        ip_q        <= req_ip_a[sel];
                        m_req_vld_q <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_arp_request_ready) begin
                        m_req_vld_q <= 1'b0;
                        m_rsp_rdy_q <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    // Error responses are passed through as-is; retry policy
                    // belongs to the requester.
                    if (m_arp_response_valid) begin
                        err_q       <= m_arp_response_error;
                        mac_q       <= m_arp_response_mac;
                        m_rsp_rdy_q <= 1'b0;
                        s_rsp_vld_q <= onehot(grant_q);
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (s_arp_response_ready[grant_q]) begin
                        s_rsp_vld_q <= '0;
                        rr_ptr      <= (grant_q == PTR_W'(N_PORTS-1)) ? '0
                                                                      : grant_q + PTR_W'(1);
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arp_req_arbiter.sv
module tb_arp_req_arbiter;

    logic        clk;
    logic        rst_n;

    // main DUT, 4 ports
    logic [3:0]   s_arp_request_valid, s_arp_request_ready;
    logic [127:0] s_arp_request_ip;
    logic [3:0]   s_arp_response_valid, s_arp_response_ready;
    logic         s_arp_response_error;
    logic [47:0]  s_arp_response_mac;
    logic         m_arp_request_valid, m_arp_request_ready;
    logic [31:0]  m_arp_request_ip;
    logic         m_arp_response_valid, m_arp_response_ready, m_arp_response_error;
    logic [47:0]  m_arp_response_mac;
    logic         busy;
    logic [1:0]   grant_id;

    // second DUT, 3 ports, with a zero-wait arp stand-in
    logic [2:0]   s_arp_request_valid3, s_arp_request_ready3;
    logic [95:0]  s_arp_request_ip3;
    logic [2:0]   s_arp_response_valid3;
    logic         s_arp_response_error3;
    logic [47:0]  s_arp_response_mac3;
    logic         m_arp_request_valid3, m_arp_request_ip_unused;
    logic [31:0]  m_arp_request_ip3;
    logic         m_arp_response_ready3;
    logic         busy3;
    logic [1:0]   grant_id3;

    arp_req_arbiter #(.N_PORTS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_arp_request_valid(s_arp_request_valid), .s_arp_request_ready(s_arp_request_ready),
        .s_arp_request_ip(s_arp_request_ip),
        .s_arp_response_valid(s_arp_response_valid), .s_arp_response_ready(s_arp_response_ready),
        .s_arp_response_error(s_arp_response_error), .s_arp_response_mac(s_arp_response_mac),
        .m_arp_request_valid(m_arp_request_valid), .m_arp_request_ready(m_arp_request_ready),
        .m_arp_request_ip(m_arp_request_ip),
        .m_arp_response_valid(m_arp_response_valid), .m_arp_response_ready(m_arp_response_ready),
        .m_arp_response_error(m_arp_response_error), .m_arp_response_mac(m_arp_response_mac),
        .busy(busy), .grant_id(grant_id)
    );

    arp_req_arbiter #(.N_PORTS(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .s_arp_request_valid(s_arp_request_valid3), .s_arp_request_ready(s_arp_request_ready3),
        .s_arp_request_ip(s_arp_request_ip3),
        .s_arp_response_valid(s_arp_response_valid3), .s_arp_response_ready(3'b111),
        .s_arp_response_error(s_arp_response_error3), .s_arp_response_mac(s_arp_response_mac3),
        .m_arp_request_valid(m_arp_request_valid3), .m_arp_request_ready(1'b1),
        .m_arp_request_ip(m_arp_request_ip3),
        .m_arp_response_valid(m_arp_response_ready3), .m_arp_response_ready(m_arp_response_ready3),
        .m_arp_response_error(1'b0), .m_arp_response_mac(48'h0000_0000_0001),
        .busy(busy3), .grant_id(grant_id3)
    );

    assign m_arp_request_ip_unused = 1'b0;
    assign s_arp_request_ip3 = {32'hc0a80302, 32'hc0a80301, 32'hc0a80300};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters / check ----------------
    int n_tests = 0;
    int n_fails = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // ---------------- requesters ----------------
    logic [31:0] req_ip [4];
    int          req_goal [4];
    int          req_done [4];
    logic [3:0]  rq_hs;

    assign s_arp_request_ip = {req_ip[3], req_ip[2], req_ip[1], req_ip[0]};

    // A port holds valid while it still owes requests, dropping it after accept.
    initial begin
        s_arp_request_valid = '0;
        for (int i = 0; i < 4; i++) req_done[i] = 0;
        forever begin
            @(posedge clk);
            rq_hs = s_arp_request_valid & s_arp_request_ready;
            #1;
            for (int i = 0; i < 4; i++) begin
                if (rq_hs[i]) req_done[i]++;
                s_arp_request_valid[i] = rst_n && (req_done[i] < req_goal[i]);
            end
        end
    end

    // ---------------- arp block stand-in ----------------
    int          arp_req_delay;
    int          arp_lat;
    int          ag_st, ag_cnt;
    logic [31:0] ag_ip;
    logic        hs_rq, hs_rs;

    initial begin
        m_arp_request_ready  = 1'b0;
        m_arp_response_valid = 1'b0;
        m_arp_response_mac   = '0;
        m_arp_response_error = 1'b0;
        ag_st = 0; ag_cnt = 0; ag_ip = '0;
        forever begin
            @(posedge clk);
            hs_rq = m_arp_request_valid & m_arp_request_ready;
            hs_rs = m_arp_response_valid & m_arp_response_ready;
            if (hs_rq) ag_ip = m_arp_request_ip;
            #1;
            if (!rst_n) begin
                m_arp_request_ready  = 1'b0;
                m_arp_response_valid = 1'b0;
                ag_st = 0; ag_cnt = 0;
            end else begin
                if (hs_rs) begin
                    m_arp_response_valid = 1'b0; ag_st = 0; ag_cnt = 0;
                end else if (hs_rq) begin
                    m_arp_request_ready = 1'b0; ag_st = 1; ag_cnt = 0;
                end
                if (ag_st == 0 && m_arp_request_valid && !m_arp_request_ready) begin
                    if (ag_cnt >= arp_req_delay) m_arp_request_ready = 1'b1;
                    else ag_cnt++;
                end else if (ag_st == 1) begin
                    if (ag_cnt >= arp_lat) begin
                        m_arp_response_valid = 1'b1;
                        if (ag_ip == 32'hc0a80164) begin
                            m_arp_response_mac = 48'h5a5152535455; m_arp_response_error = 1'b0;
                        end else if (ag_ip[15:8] == 8'h02) begin
                            m_arp_response_mac = {16'hdead, ag_ip}; m_arp_response_error = 1'b1;
                        end else begin
                            m_arp_response_mac = {16'h0200, ag_ip}; m_arp_response_error = 1'b0;
                        end
                        ag_st = 2;
                    end else ag_cnt++;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Transaction view: stage 0 = free, 1 = request owed to arp,
    // 2 = awaiting arp answer, 3 = answer owed to the owner.
    int          m_stg, m_ptr, m_g, mp;
    logic [31:0] m_ip;
    logic [47:0] m_mac;
    logic        m_err;
    int          glog [$];

    // Nearest valid port at or after the pointer, by circular distance.
    function automatic int pick4(input logic [3:0] v, input int ptr);
        int best, bd, d;
        best = -1; bd = 4;
        for (int i = 0; i < 4; i++) begin
            d = (i - ptr + 4) % 4;
            if (v[i] && d < bd) begin best = i; bd = d; end
        end
        return best;
    endfunction

    function automatic logic [3:0] oh4(input int p);
        logic [3:0] r;
        r = '0;
        if (p >= 0) r[p] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stg = 0; m_ptr = 0; m_g = 0; m_ip = '0; m_mac = '0; m_err = 1'b0;
        end else begin
            case (m_stg)
                0: begin
                    mp = pick4(s_arp_request_valid, m_ptr);
                    if (mp >= 0) begin
                        m_g = mp; m_ip = req_ip[mp]; m_stg = 1; glog.push_back(mp);
                    end
                end
                1: if (m_arp_request_ready) m_stg = 2;
                2: if (m_arp_response_valid) begin
                       m_mac = m_arp_response_mac; m_err = m_arp_response_error; m_stg = 3;
                   end
                default: if (s_arp_response_ready[m_g]) begin
                       m_stg = 0; m_ptr = (m_g + 1) % 4;
                   end
            endcase
        end
    end

    logic [3:0] exp_rdy;
    always @(negedge clk) begin
        if (rst_n) begin
            exp_rdy = (m_stg == 0) ? oh4(pick4(s_arp_request_valid, m_ptr)) : 4'b0;
            chk("req_ready", s_arp_request_ready, exp_rdy);
            chk("busy", busy, m_stg != 0);
            chk("grant_id", grant_id, m_g[1:0]);
            chk("m_req_valid", m_arp_request_valid, m_stg == 1);
            chk("m_req_ip", m_arp_request_ip, m_ip);
            chk("m_resp_ready", m_arp_response_ready, m_stg == 2);
            chk("s_resp_valid", s_arp_response_valid, (m_stg == 3) ? oh4(m_g) : 4'b0);
            if (m_stg == 3) begin
                chk("s_resp_mac", s_arp_response_mac, m_mac);
                chk("s_resp_err", s_arp_response_error, m_err);
            end
        end
    end

    // grant log of the 3-port instance
    int log3 [$];
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (s_arp_request_valid3[i] && s_arp_request_ready3[i]) log3.push_back(i);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int k, base;
        rst_n = 1'b0;
        s_arp_response_ready = 4'hf;
        s_arp_request_valid3 = 3'b000;
        arp_req_delay = 0;
        arp_lat = 2;
        for (int i = 0; i < 4; i++) begin
            req_goal[i] = 0;
            req_ip[i]   = 32'hc0a80110 + i;
        end
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_m_req_valid", m_arp_request_valid, 0);
        chk("rst_m_req_ip", m_arp_request_ip, 0);
        chk("rst_m_resp_ready", m_arp_response_ready, 0);
        chk("rst_s_resp_valid", s_arp_response_valid, 0);
        chk("rst_s_req_ready", s_arp_request_ready, 0);
        chk("rst_mac", s_arp_response_mac, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: single lookup on port 0
        req_ip[0] = 32'hc0a80164;
        req_goal[0] = 1;
        k = 0;
        while (s_arp_response_valid == 4'b0 && k < 100) begin @(negedge clk); k++; end
        chk("t1_resp_seen", k < 100, 1);
        chk("t1_resp_valid", s_arp_response_valid, 4'b0001);
        chk("t1_mac", s_arp_response_mac, 48'h5a5152535455);
        chk("t1_err", s_arp_response_error, 0);
        k = 0;
        while (busy && k < 100) begin @(negedge clk); k++; end
        chk("t1_idle", busy, 0);

        // 2: all four ports valid out of reset, port 0 twice
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req_ip[0] = 32'hc0a80110;
        base = glog.size();
        req_goal[0] = req_done[0] + 2;
        for (int i = 1; i < 4; i++) req_goal[i] = req_done[i] + 1;
        k = 0;
        while ((glog.size() < base + 5 || busy) && k < 300) begin @(negedge clk); k++; end
        chk("t2_done", k < 300, 1);
        if (glog.size() >= base + 5) begin
            chk("t2_g0", glog[base+0], 0);
            chk("t2_g1", glog[base+1], 1);
            chk("t2_g2", glog[base+2], 2);
            chk("t2_g3", glog[base+3], 3);
            chk("t2_g4", glog[base+4], 0);
        end

        // 3: unresolved off-subnet address on port 2
        req_ip[2] = 32'hc0a80299;
        req_goal[2] = req_done[2] + 1;
        k = 0;
        while (s_arp_response_valid == 4'b0 && k < 100) begin @(negedge clk); k++; end
        chk("t3_resp_valid", s_arp_response_valid, 4'b0100);
        chk("t3_err", s_arp_response_error, 1);
        chk("t3_mac", s_arp_response_mac, 48'hdead_c0a80299);
        k = 0;
        while (busy && k < 100) begin @(negedge clk); k++; end

        // 4: arp stalls request, port 1 stalls response; port 3 must wait
        arp_req_delay = 20;
        s_arp_response_ready = 4'b1101;
        base = glog.size();
        req_goal[1] = req_done[1] + 1;
        k = 0;
        while (!m_arp_request_valid && k < 50) begin @(negedge clk); k++; end
        repeat (10) @(negedge clk);
        req_goal[3] = req_done[3] + 1;
        repeat (5) @(negedge clk);
        chk("t4_req_held", m_arp_request_valid, 1);
        chk("t4_grant", grant_id, 1);
        chk("t4_ip_stable", m_arp_request_ip, 32'hc0a80111);
        chk("t4_no_2nd_grant", s_arp_request_ready, 4'b0000);
        k = 0;
        while (s_arp_response_valid == 4'b0 && k < 100) begin @(negedge clk); k++; end
        repeat (10) @(negedge clk);
        chk("t4_resp_held", s_arp_response_valid, 4'b0010);
        chk("t4_mac_held", s_arp_response_mac, 48'h0200_c0a80111);
        s_arp_response_ready = 4'hf;
        arp_req_delay = 0;
        k = 0;
        while ((glog.size() < base + 2 || busy) && k < 100) begin @(negedge clk); k++; end
        chk("t4_done", k < 100, 1);
        if (glog.size() >= base + 2) chk("t4_next_port", glog[base+1], 3);

        // 5: reset while waiting on arp
        arp_lat = 40;
        req_goal[1] = req_done[1] + 1;
        k = 0;
        while (!m_arp_response_ready && k < 50) begin @(negedge clk); k++; end
        chk("t5_in_wait", m_arp_response_ready, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_m_resp_ready", m_arp_response_ready, 0);
        chk("t5_rst_grant", grant_id, 0);
        chk("t5_rst_s_resp_valid", s_arp_response_valid, 0);
        chk("t5_rst_m_req_ip", m_arp_request_ip, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        arp_lat = 2;
        base = glog.size();
        req_goal[0] = req_done[0] + 1;
        req_goal[2] = req_done[2] + 1;
        k = 0;
        while ((glog.size() < base + 2 || busy) && k < 100) begin @(negedge clk); k++; end
        chk("t5_done", k < 100, 1);
        if (glog.size() >= base + 2) begin
            chk("t5_first_after_rst", glog[base+0], 0);
            chk("t5_second", glog[base+1], 2);
        end

        // 6: 3-port build, ports 1 and 2 continuously requesting
        s_arp_request_valid3 = 3'b110;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk("t6_grant_known", $isunknown(grant_id3), 0);
            chk("t6_ready_onehot", $countones(s_arp_request_ready3) <= 1, 1);
        end
        s_arp_request_valid3 = 3'b000;
        chk("t6_count", log3.size() >= 4, 1);
        if (log3.size() >= 4) begin
            chk("t6_g0", log3[0], 1);
            chk("t6_g1", log3[1], 2);
            chk("t6_g2", log3[2], 1);
            chk("t6_g3", log3[3], 2);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
